staged_reset_sequencer: RTL and testbench

//  Upstream reset stage for the board top level: combines asynchronous active-low reset sources
//  (pushbutton, PLL lock, DDR PHY reset) into PLL areset, per-domain staged resets and one

---
 rtl/staged_reset_sequencer_if.sv | 23 ++
 rtl/staged_reset_sequencer.sv | 131 +++++++++++++
 tb/tb_staged_reset_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/staged_reset_sequencer_if.sv
// rtl/staged_reset_sequencer_if.sv - reset sources in, staged resets and status out
interface staged_reset_sequencer_if #(
  parameter int RESET_SOURCES_WIDTH = 3,
  parameter int STAGES              = 3
);
  logic [RESET_SOURCES_WIDTH-1:0] resetn_sources;
  logic                           pll_locked;
  logic                           pll_areset;
  logic [STAGES-1:0]              stage_resetn;
  logic                           global_resetn;
  logic                           lock_timeout_flag;
  logic [1:0]                     seq_state;

  modport master (
    output resetn_sources, pll_locked,
    input  pll_areset, stage_resetn, global_resetn, lock_timeout_flag, seq_state
  );

  modport slave (
    input  resetn_sources, pll_locked,
    output pll_areset, stage_resetn, global_resetn, lock_timeout_flag, seq_state
  );
endinterface

// File: rtl/staged_reset_sequencer.sv
// rtl/staged_reset_sequencer.sv - staged board reset sequencer with PLL lock wait
module staged_reset_sequencer #(
  parameter int RESET_SOURCES_WIDTH = 3,
  parameter int RESET_COUNTER_WIDTH = 8,
  parameter int STAGES              = 3,
  parameter int STAGE_DELAY_WIDTH   = 4,
  parameter int LOCK_TIMEOUT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  staged_reset_sequencer_if.slave        bus
);
  localparam logic [1:0] HOLD     = 2'd0;
  localparam logic [1:0] PLL_WAIT = 2'd1;
  localparam logic [1:0] RELEASE  = 2'd2;
  localparam logic [1:0] RUN      = 2'd3;
  localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STAGES - 1);
  localparam int NSYNC = RESET_SOURCES_WIDTH + 1;

  logic [NSYNC-1:0] raw;
  logic [NSYNC-1:0] synced;
  logic             src_ok, lock_ok, abort;

  logic [1:0]                     state, next_state;
  logic [RESET_COUNTER_WIDTH-1:0] hold_cnt, hold_cnt_d;
  logic [LOCK_TIMEOUT_WIDTH-1:0]  lock_cnt, lock_cnt_d;
  logic [STAGE_DELAY_WIDTH-1:0]   delay_cnt, delay_cnt_d;
  logic [IDX_W-1:0]               idx, idx_d;
  logic [STAGES-1:0]              stage_q, stage_d;
  logic                           areset_q, areset_d;
  logic                           global_q, global_d;
  logic                           flag_q, flag_d;

  assign raw = {bus.pll_locked, bus.resetn_sources};

  // Each input clears its own synchronizer asynchronously, so loss is seen before the next edge.
  for (genvar i = 0; i < NSYNC; i++) begin : g_sync
    logic       raw_i;
    logic [1:0] sync_ff;
    assign raw_i = raw[i];
    always_ff @(posedge clk or negedge reset_n or negedge raw_i) begin
      if (!reset_n || !raw_i) sync_ff <= 2'b00;
      else                    sync_ff <= {sync_ff[0], 1'b1};
    end
    assign synced[i] = sync_ff[1];
  end

  assign src_ok  = &synced[RESET_SOURCES_WIDTH-1:0];
  assign lock_ok = synced[NSYNC-1];
  assign abort   = !src_ok || (((state == RELEASE) || (state == RUN)) && !lock_ok);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= HOLD;
      hold_cnt  <= '0;
      lock_cnt  <= '0;
      delay_cnt <= '0;
      idx       <= '0;
      stage_q   <= '0;
      areset_q  <= 1'b1;
      global_q  <= 1'b0;
      flag_q    <= 1'b0;
    end else begin
      state     <= next_state;
      hold_cnt  <= hold_cnt_d;
      lock_cnt  <= lock_cnt_d;
      delay_cnt <= delay_cnt_d;
      idx       <= idx_d;
      stage_q   <= stage_d;
      areset_q  <= areset_d;
      global_q  <= global_d;
      flag_q    <= flag_d;
    end
  end

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = HOLD;
    end else begin
      case (state)
        HOLD:     if (hold_cnt == '1) next_state = PLL_WAIT;
        PLL_WAIT: if (lock_ok) next_state = RELEASE;
                  else if (lock_cnt == '1) next_state = HOLD;
        RELEASE:  if ((delay_cnt == '1) && (idx == LAST_IDX)) next_state = RUN;
        default:  next_state = state;
      endcase
    end
  end

  // Counters and stage bits default to cleared; only the active state keeps or advances them.
  always_comb begin
    hold_cnt_d  = '0;
    lock_cnt_d  = '0;
    delay_cnt_d = '0;
    idx_d       = '0;
    stage_d     = '0;
    flag_d      = flag_q;
    if (!abort) begin
      case (state)
        HOLD: begin
          if (hold_cnt != '1) hold_cnt_d = hold_cnt + 1'b1;
        end
        PLL_WAIT: begin
          lock_cnt_d = lock_cnt + 1'b1;
          if (!lock_ok && (lock_cnt == '1)) flag_d = 1'b1;
        end
        RELEASE: begin
          delay_cnt_d = delay_cnt + 1'b1;
          idx_d       = idx;
          stage_d     = stage_q;
          if (delay_cnt == '1) begin
            idx_d = idx + 1'b1;
            for (int k = 0; k < STAGES; k++)
              if (idx == IDX_W'(k)) stage_d[k] = 1'b1;
          end
        end
        default: stage_d = stage_q;
      endcase
    end
    areset_d = (next_state == HOLD);
    global_d = (next_state == RUN);
  end

  assign bus.pll_areset        = areset_q;
  assign bus.stage_resetn      = stage_q;
  assign bus.global_resetn     = global_q;
  assign bus.lock_timeout_flag = flag_q;
  assign bus.seq_state         = state;
endmodule

// File: tb/tb_staged_reset_sequencer.sv
// tb/tb_staged_reset_sequencer.sv - directed bench for staged_reset_sequencer
module tb_staged_reset_sequencer;
  localparam int RSW = 3;
  localparam int STG = 3;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  staged_reset_sequencer_if #(.RESET_SOURCES_WIDTH(RSW), .STAGES(STG)) bus ();

  staged_reset_sequencer #(
    .RESET_SOURCES_WIDTH(RSW),
    .RESET_COUNTER_WIDTH(8),
    .STAGES(STG),
    .STAGE_DELAY_WIDTH(4),
    .LOCK_TIMEOUT_WIDTH(6)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [1:0] s, input int limit, output int n);
    n = 0;
    while ((bus.seq_state !== s) && (n < limit)) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.resetn_sources = 3'b111;
    bus.pll_locked = 1'b1;
    step(3);
    checks++; if (bus.seq_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", bus.seq_state); end
    checks++; if (bus.pll_areset !== 1'b1) begin errors++; $display("FAIL reset_areset got=%b exp=1", bus.pll_areset); end
    checks++; if (bus.stage_resetn !== 3'b000) begin errors++; $display("FAIL reset_stages got=%b exp=000", bus.stage_resetn); end
    checks++; if (bus.global_resetn !== 1'b0) begin errors++; $display("FAIL reset_global got=%b exp=0", bus.global_resetn); end
    checks++; if (bus.lock_timeout_flag !== 1'b0) begin errors++; $display("FAIL reset_flag got=%b exp=0", bus.lock_timeout_flag); end
    reset_n = 1'b1;
  endtask

  task automatic test_sequence();
    step(257);
    checks++; if (bus.seq_state !== 2'd0) begin errors++; $display("FAIL seq_hold_end got=%0d exp=0", bus.seq_state); end
    step(1);
    checks++; if (bus.seq_state !== 2'd1 || bus.pll_areset !== 1'b0) begin errors++; $display("FAIL seq_pll_wait state=%0d areset=%b exp=1/0", bus.seq_state, bus.pll_areset); end
    step(1);
    checks++; if (bus.seq_state !== 2'd2) begin errors++; $display("FAIL seq_release got=%0d exp=2", bus.seq_state); end
    step(15);
    checks++; if (bus.stage_resetn !== 3'b000) begin errors++; $display("FAIL seq_pre_s0 got=%b exp=000", bus.stage_resetn); end
    step(1);
    checks++; if (bus.stage_resetn !== 3'b001) begin errors++; $display("FAIL seq_s0 got=%b exp=001", bus.stage_resetn); end
    step(15);
    checks++; if (bus.stage_resetn !== 3'b001) begin errors++; $display("FAIL seq_pre_s1 got=%b exp=001", bus.stage_resetn); end
    step(1);
    checks++; if (bus.stage_resetn !== 3'b011) begin errors++; $display("FAIL seq_s1 got=%b exp=011", bus.stage_resetn); end
    step(15);
    checks++; if (bus.stage_resetn !== 3'b011 || bus.global_resetn !== 1'b0) begin errors++; $display("FAIL seq_pre_s2 stages=%b global=%b exp=011/0", bus.stage_resetn, bus.global_resetn); end
    step(1);
    checks++; if (bus.stage_resetn !== 3'b111 || bus.global_resetn !== 1'b1 || bus.seq_state !== 2'd3) begin
      errors++; $display("FAIL seq_run stages=%b global=%b state=%0d exp=111/1/3", bus.stage_resetn, bus.global_resetn, bus.seq_state);
    end
  endtask

  task automatic test_source_glitch();
    int n;
    bus.resetn_sources = 3'b011;
    step(1);
    checks++; if (bus.seq_state !== 2'd0 || bus.stage_resetn !== 3'b000 || bus.global_resetn !== 1'b0 || bus.pll_areset !== 1'b1) begin
      errors++; $display("FAIL glitch_drop state=%0d stages=%b global=%b areset=%b exp=0/000/0/1", bus.seq_state, bus.stage_resetn, bus.global_resetn, bus.pll_areset);
    end
    bus.resetn_sources = 3'b111;
    step(257);
    checks++; if (bus.seq_state !== 2'd0) begin errors++; $display("FAIL glitch_hold got=%0d exp=0", bus.seq_state); end
    step(1);
    checks++; if (bus.seq_state !== 2'd1) begin errors++; $display("FAIL glitch_pll_wait got=%0d exp=1", bus.seq_state); end
    wait_state(2'd3, 200, n);
    checks++; if (bus.seq_state !== 2'd3 || bus.global_resetn !== 1'b1) begin errors++; $display("FAIL glitch_rerun state=%0d global=%b exp=3/1", bus.seq_state, bus.global_resetn); end
  endtask

  task automatic test_lock_timeout();
    int n;
    bus.pll_locked = 1'b0;
    step(1);
    checks++; if (bus.seq_state !== 2'd0 || bus.global_resetn !== 1'b0) begin errors++; $display("FAIL to_lock_loss state=%0d global=%b exp=0/0", bus.seq_state, bus.global_resetn); end
    step(255);
    checks++; if (bus.seq_state !== 2'd0) begin errors++; $display("FAIL to_hold got=%0d exp=0", bus.seq_state); end
    step(1);
    checks++; if (bus.seq_state !== 2'd1 || bus.lock_timeout_flag !== 1'b0) begin errors++; $display("FAIL to_wait state=%0d flag=%b exp=1/0", bus.seq_state, bus.lock_timeout_flag); end
    step(63);
    checks++; if (bus.seq_state !== 2'd1 || bus.pll_areset !== 1'b0) begin errors++; $display("FAIL to_wait_end state=%0d areset=%b exp=1/0", bus.seq_state, bus.pll_areset); end
    step(1);
    checks++; if (bus.seq_state !== 2'd0 || bus.pll_areset !== 1'b1 || bus.lock_timeout_flag !== 1'b1) begin
      errors++; $display("FAIL to_expire state=%0d areset=%b flag=%b exp=0/1/1", bus.seq_state, bus.pll_areset, bus.lock_timeout_flag);
    end
    bus.pll_locked = 1'b1;
    wait_state(2'd3, 600, n);
    checks++; if (bus.seq_state !== 2'd3 || bus.lock_timeout_flag !== 1'b1 || bus.global_resetn !== 1'b1) begin
      errors++; $display("FAIL to_recover state=%0d flag=%b global=%b exp=3/1/1", bus.seq_state, bus.lock_timeout_flag, bus.global_resetn);
    end
  endtask

  task automatic test_lock_drop();
    int n;
    bus.resetn_sources = 3'b110;
    step(1);
    bus.resetn_sources = 3'b111;
    wait_state(2'd2, 400, n);
    checks++; if (bus.seq_state !== 2'd2) begin errors++; $display("FAIL drop_release got=%0d exp=2", bus.seq_state); end
    step(16);
    checks++; if (bus.stage_resetn !== 3'b001) begin errors++; $display("FAIL drop_s0 got=%b exp=001", bus.stage_resetn); end
    bus.pll_locked = 1'b0;
    step(1);
    checks++; if (bus.seq_state !== 2'd0 || bus.stage_resetn !== 3'b000 || bus.pll_areset !== 1'b1) begin
      errors++; $display("FAIL drop_abort state=%0d stages=%b areset=%b exp=0/000/1", bus.seq_state, bus.stage_resetn, bus.pll_areset);
    end
    bus.pll_locked = 1'b1;
  endtask

  task automatic test_hold_interrupt();
    bus.resetn_sources = 3'b101;
    step(1);
    bus.resetn_sources = 3'b111;
    step(202);
    checks++; if (bus.seq_state !== 2'd0) begin errors++; $display("FAIL hi_pre got=%0d exp=0", bus.seq_state); end
    bus.resetn_sources = 3'b101;
    step(1);
    bus.resetn_sources = 3'b111;
    step(100);
    checks++; if (bus.seq_state !== 2'd0) begin errors++; $display("FAIL hi_no_early got=%0d exp=0", bus.seq_state); end
    step(157);
    checks++; if (bus.seq_state !== 2'd0) begin errors++; $display("FAIL hi_hold_end got=%0d exp=0", bus.seq_state); end
    step(1);
    checks++; if (bus.seq_state !== 2'd1) begin errors++; $display("FAIL hi_pll_wait got=%0d exp=1", bus.seq_state); end
  endtask

  task automatic test_async_reset();
    int n;
    wait_state(2'd3, 200, n);
    checks++; if (bus.seq_state !== 2'd3 || bus.global_resetn !== 1'b1) begin errors++; $display("FAIL ar_run state=%0d global=%b exp=3/1", bus.seq_state, bus.global_resetn); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.seq_state !== 2'd0 || bus.stage_resetn !== 3'b000 || bus.global_resetn !== 1'b0 ||
                  bus.pll_areset !== 1'b1 || bus.lock_timeout_flag !== 1'b0) begin
      errors++; $display("FAIL ar_immediate state=%0d stages=%b global=%b areset=%b flag=%b exp=0/000/0/1/0",
                         bus.seq_state, bus.stage_resetn, bus.global_resetn, bus.pll_areset, bus.lock_timeout_flag);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step(2);
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_source_glitch();
    test_lock_timeout();
    test_lock_drop();
    test_hold_interrupt();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
